// File: rtl/soundpath_poly.sv
// Polyphonic sound path: NUM_VOICES oscillators time-multiplexed through one
// datapath (one voice per clk), mixed into a single unsigned sample per request.
module soundpath_poly #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 9,
  parameter int PHASE_W    = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_now,
  input  logic [NUM_VOICES-1:0]   voice_en,
  input  logic [2*NUM_VOICES-1:0] mode,
  input  logic [4*NUM_VOICES-1:0] note,
  input  logic [3*NUM_VOICES-1:0] octave,
  output logic [SAMPLE_W-1:0]     sample,
  output logic                    done,
  output logic                    overrun
);

  localparam int LOG2V  = $clog2(NUM_VOICES);
  localparam int VIDX_W = (LOG2V > 0) ? LOG2V : 1;
  localparam int ACC_W  = SAMPLE_W + LOG2V;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                               state, state_nxt;
  logic [VIDX_W-1:0]                    vidx;
  logic [ACC_W-1:0]                     acc;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]   phase;
  logic [15:0]                          lfsr;
  logic                                 lfsr_fb;

  // Per-octave-0 phase increments for C..B at FS = 46875 Hz (A = note 10 = 27.5 Hz).
  function automatic logic [15:0] base_inc(input logic [3:0] n);
    case (n)
      4'd1:    base_inc = 16'd5852;
      4'd2:    base_inc = 16'd6200;
      4'd3:    base_inc = 16'd6569;
      4'd4:    base_inc = 16'd6960;
      4'd5:    base_inc = 16'd7374;
      4'd6:    base_inc = 16'd7812;
      4'd7:    base_inc = 16'd8277;
      4'd8:    base_inc = 16'd8769;
      4'd9:    base_inc = 16'd9290;
      4'd10:   base_inc = 16'd9843;
      4'd11:   base_inc = 16'd10428;
      4'd12:   base_inc = 16'd11048;
      default: base_inc = 16'd0;
    endcase
  endfunction

  // Current voice fields, selected by vidx
  logic [1:0]          v_mode;
  logic [3:0]          v_note;
  logic [2:0]          v_oct;
  logic                v_active;
  logic [PHASE_W-1:0]  v_phase, v_inc;
  logic [SAMPLE_W:0]   p;
  logic [SAMPLE_W-1:0] wave;

  assign v_mode   = mode[2*int'(vidx) +: 2];
  assign v_note   = note[4*int'(vidx) +: 4];
  assign v_oct    = octave[3*int'(vidx) +: 3];
  assign v_active = voice_en[vidx] && (v_note >= 4'd1) && (v_note <= 4'd12);
  assign v_phase  = phase[vidx];
  assign v_inc    = PHASE_W'(base_inc(v_note)) << v_oct;
  assign p        = v_phase[PHASE_W-1 -: SAMPLE_W+1];
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    wave = '0;
    case (v_mode)
      2'd0:    wave = p[SAMPLE_W] ? '1 : '0;
      2'd1:    wave = p[SAMPLE_W:1];
      2'd2:    wave = p[SAMPLE_W] ? ~p[SAMPLE_W-1:0] : p[SAMPLE_W-1:0];
      default: wave = lfsr[SAMPLE_W-1:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_now) state_nxt = CALC;
      CALC:    if (vidx == VIDX_W'(NUM_VOICES-1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sample  <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      phase   <= '0;
      lfsr    <= 16'hACE1;
      vidx    <= '0;
      acc     <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == OUT);
      if (state != IDLE && sample_now) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_now) begin
          acc  <= '0;
          vidx <= '0;
        end
        CALC: begin
          // waveform uses the pre-update phase; inactive voices hold phase
          if (v_active) begin
            acc         <= acc + ACC_W'(wave);
            phase[vidx] <= v_phase + v_inc;
          end
          vidx <= vidx + VIDX_W'(1);
        end
        OUT: begin
          sample <= SAMPLE_W'(acc >> LOG2V);
          lfsr   <= {lfsr[14:0], lfsr_fb};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soundpath_poly.sv
// Bench for soundpath_poly: hand-derived vector table, directed corner cases,
// and randomized configs checked against an arithmetic reference model.
module tb_soundpath_poly;
  localparam int NV = 4;

  logic        tb_clk = 1'b0;
  logic        tb_Rst_i;
  logic        sample_now;
  logic [3:0]  voice_en;
  logic [7:0]  mode;
  logic [15:0] note;
  logic [11:0] octave;
  logic [8:0]  sample;
  logic        done, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  soundpath_poly #(.NUM_VOICES(NV), .SAMPLE_W(9), .PHASE_W(24)) dut (
    .clk(tb_clk), .rst(tb_Rst_i), .sample_now(sample_now), .voice_en(voice_en),
    .mode(mode), .note(note), .octave(octave),
    .sample(sample), .done(done), .overrun(overrun)
  );

  // Reference model state
  longint m_phase[NV];
  int     m_lfsr;

  function automatic int base_of(input int n);
    if (n < 1 || n > 12) return 0;
    return int'(27.5 * (2.0 ** ((n - 10) / 12.0)) * 16777216.0 / 46875.0);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_phase[v] = 0;
    m_lfsr = 'hACE1;
  endtask

  task automatic model_step(output int exp);
    int sum, md, nt, oc, pp, w, fb;
    longint inc;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      md = int'(mode[2*v +: 2]);
      nt = int'(note[4*v +: 4]);
      oc = int'(octave[3*v +: 3]);
      if (voice_en[v] && nt >= 1 && nt <= 12) begin
        inc = (longint'(base_of(nt)) << oc) % (64'd1 << 24);
        pp  = int'(m_phase[v] >> 14);
        case (md)
          0:       w = (pp >= 512) ? 511 : 0;
          1:       w = pp / 2;
          2:       w = (pp >= 512) ? 1023 - pp : pp;
          default: w = m_lfsr % 512;
        endcase
        sum += w;
        m_phase[v] = (m_phase[v] + inc) % (64'd1 << 24);
      end
    end
    exp = sum / NV;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge tb_clk);
    tb_Rst_i = 1'b1; sample_now = 1'b0;
    repeat (2) @(negedge tb_clk);
    tb_Rst_i = 1'b0;
    model_reset();
  endtask

  task automatic pulse_wait(output int lat, output int got);
    @(negedge tb_clk) sample_now = 1'b1;
    @(negedge tb_clk) sample_now = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge tb_clk);
      if (done) begin lat = c; break; end
    end
    got = int'(sample);
  endtask

  task automatic run_sample(input string nm, output int got);
    int lat, exp;
    pulse_wait(lat, got);
    model_step(exp);
    check({nm, " latency"}, lat, 5);
    check({nm, " sample"}, got, exp);
  endtask

  task automatic cfg(input logic [3:0] e, input logic [7:0] m, input logic [15:0] n,
                     input logic [11:0] o);
    voice_en = e; mode = m; note = n; octave = o;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [7:0]  md;
    logic [15:0] nt;
    logic [11:0] oc;
    int          s1;
    int          s2;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int g, lat, cnt, rises, bad, first_hi, prev;
    tb_Rst_i = 1'b1; sample_now = 1'b0;
    cfg(4'h0, 8'h00, 16'h0000, 12'h000);

    // first two samples after reset, derived by hand
    tbl[0] = '{4'h1, 8'h01, 16'h000A, 12'h007, 0, 9};     // saw A oct7
    tbl[1] = '{4'h1, 8'h02, 16'h000A, 12'h007, 0, 19};    // triangle
    tbl[2] = '{4'h1, 8'h03, 16'h000A, 12'h007, 56, 112};  // noise, one voice
    tbl[3] = '{4'hF, 8'hFF, 16'hAAAA, 12'hFFF, 225, 451}; // noise, all voices
    tbl[4] = '{4'h1, 8'h01, 16'h0000, 12'h007, 0, 0};     // note 0 = rest
    tbl[5] = '{4'h1, 8'h03, 16'h000D, 12'h007, 0, 0};     // note 13 = rest
    tbl[6] = '{4'h0, 8'hFF, 16'hAAAA, 12'hFFF, 0, 0};     // all disabled
    tbl[7] = '{4'h3, 8'h09, 16'h00AA, 12'h03F, 0, 28};    // saw + triangle mix

    // T1: reset state and latency
    do_reset();
    check("reset sample", int'(sample), 0);
    check("reset done", int'(done), 0);
    check("reset overrun", int'(overrun), 0);
    run_sample("t1", g);
    check("t1 overrun", int'(overrun), 0);
    @(negedge tb_clk);
    check("t1 done one cycle", int'(done), 0);

    foreach (tbl[i]) begin
      do_reset();
      cfg(tbl[i].en, tbl[i].md, tbl[i].nt, tbl[i].oc);
      run_sample($sformatf("tbl%0d s1", i), g);
      check($sformatf("tbl%0d s1 const", i), g, tbl[i].s1);
      run_sample($sformatf("tbl%0d s2", i), g);
      check($sformatf("tbl%0d s2 const", i), g, tbl[i].s2);
    end
    do_reset();
    cfg(4'h1, 8'h01, 16'h000C, 12'h007);
    run_sample("note12 s1", g);
    run_sample("note12 s2", g);
    check("note12 s2 const", g, 10);

    // T2: square A4 on voice 0
    do_reset();
    cfg(4'h1, 8'h00, 16'h000A, 12'h004);
    rises = 0; bad = 0; first_hi = -1; prev = 0;
    for (int i = 0; i < 220; i++) begin
      run_sample("t2", g);
      if (g != 0 && g != 127) bad++;
      if (g == 127 && prev == 0) begin
        rises++;
        if (first_hi < 0) first_hi = i;
      end
      prev = g;
    end
    check("t2 bad levels", bad, 0);
    check("t2 rises", rises, 2);
    check("t2 first high", first_hi, 54);

    // T3: saw C0 rises monotonically
    do_reset();
    cfg(4'h1, 8'h01, 16'h0001, 12'h000);
    bad = 0; prev = 0;
    for (int i = 0; i < 30; i++) begin
      run_sample("t3", g);
      if (g < prev) bad++;
      prev = g;
    end
    check("t3 monotonic", bad, 0);

    // T4: four squares in lockstep
    do_reset();
    cfg(4'hF, 8'h00, 16'hAAAA, 12'h924);
    run_sample("t4 first", g);
    check("t4 first const", g, 0);
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      run_sample("t4", g);
      if (g != 0 && g != 511) bad++;
    end
    check("t4 bad levels", bad, 0);

    // T5: second request 2 cycles after the first is dropped
    do_reset();
    cfg(4'h0, 8'h00, 16'h0000, 12'h000);
    @(negedge tb_clk) sample_now = 1'b1;
    @(negedge tb_clk) sample_now = 1'b0;
    @(negedge tb_clk) sample_now = 1'b1;
    @(negedge tb_clk) sample_now = 1'b0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge tb_clk);
      if (done) cnt++;
    end
    check("t5 done count", cnt, 1);
    check("t5 overrun", int'(overrun), 1);
    pulse_wait(lat, g);
    pulse_wait(lat, g);
    check("t5 overrun sticky", int'(overrun), 1);
    do_reset();
    check("t5 overrun cleared", int'(overrun), 0);

    // T6: reset during voice 2's CALC cycle
    cfg(4'h1, 8'h01, 16'h000A, 12'h007);
    run_sample("t6 pre", g);
    @(negedge tb_clk) sample_now = 1'b1;
    @(negedge tb_clk) sample_now = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk) tb_Rst_i = 1'b1;
    @(negedge tb_clk) tb_Rst_i = 1'b0;
    model_reset();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge tb_clk);
      if (done) cnt++;
    end
    check("t6 no done", cnt, 0);
    check("t6 sample", int'(sample), 0);
    run_sample("t6 s1", g);
    check("t6 s1 const", g, 0);
    run_sample("t6 s2", g);
    check("t6 s2 const", g, 9);

    // randomized configurations against the model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      cfg(4'($urandom), 8'($urandom), 16'($urandom), 12'($urandom));
      run_sample($sformatf("rand%0d", i), g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
